// File: rtl/uart_rx_sink.sv
// UART receiver: 8N1 (8E1 with UART_RX_SINK_PARITY_EN) framing into a byte FIFO
// that drains through a valid/ready stream.
module uart_rx_sink #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_rx,
  output logic [7:0]       o_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [LVL_W-1:0] o_level,
  output logic             o_frame_err,
  output logic             o_parity_err,
  output logic             o_overflow,
  input  logic             i_clr_overflow
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LD = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_SINK_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             sync1, rxs;
  logic             push, ferr_d, perr_d;
  logic             cnt_zero;
`ifdef UART_RX_SINK_PARITY_EN
  logic             pend_q, pend_d;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty, pop, wr_en;

  assign cnt_zero = (cnt_q == '0);

  // IDLE is only ever entered with rxs high, so a low rxs there is a falling edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
    perr_d  = 1'b0;
`ifdef UART_RX_SINK_PARITY_EN
    pend_d  = pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          cnt_d   = HALF_LD;
          state_d = S_START;
        end
      end
      S_START: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxs) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = FULL_LD;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          shift_d = {rxs, shift_q[7:1]};
          cnt_d   = FULL_LD;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_SINK_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_SINK_PARITY_EN
      S_PARITY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          pend_d  = rxs ^ (^shift_q);
          cnt_d   = FULL_LD;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (rxs) begin
`ifdef UART_RX_SINK_PARITY_EN
          perr_d = pend_q;
          push   = !pend_q;
`else
          push   = 1'b1;
`endif
          state_d = S_IDLE;
        end else begin
          ferr_d  = 1'b1;
          state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1   <= 1'b1;
      rxs     <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
`ifdef UART_RX_SINK_PARITY_EN
      pend_q  <= 1'b0;
`endif
    end else begin
      sync1   <= i_rx;
      rxs     <= sync1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
`ifdef UART_RX_SINK_PARITY_EN
      pend_q  <= pend_d;
`endif
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = ((wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}});
  assign pop   = i_ready && !empty;
  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_overflow   <= 1'b0;
      o_frame_err  <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      if (push && full && !pop) o_overflow <= 1'b1;
      else if (i_clr_overflow)  o_overflow <= 1'b0;
      o_frame_err  <= ferr_d;
      o_parity_err <= perr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= shift_q;
  end

  assign o_data  = mem[rd_ptr[AW-1:0]];
  assign o_valid = !empty;
  assign o_level = LVL_W'(wr_ptr - rd_ptr);

endmodule

// File: tb/tb_uart_rx_sink.sv
// Self-checking bench for uart_rx_sink: queue-based model of received bytes,
// randomized payloads, error/glitch/overflow/reset scenarios.
module tb_uart_rx_sink;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef UART_RX_SINK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Negedges from the start-bit drive to the cycle holding the stop-sample decision.
  localparam int STOP_OFF = 2 + CPB / 2 + (9 + PAR) * CPB;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx = 1'b1;
  logic             ready = 1'b0;
  logic             clr = 1'b0;
  logic [7:0]       o_data;
  logic             o_valid;
  logic [LVL_W-1:0] o_level;
  logic             o_frame_err, o_parity_err, o_overflow;

  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0, ferr_cnt = 0, perr_cnt = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] model_q[$];
  bit         model_ovf = 1'b0;

  uart_rx_sink #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx(rx), .o_data(o_data), .o_valid(o_valid),
    .i_ready(ready), .o_level(o_level), .o_frame_err(o_frame_err),
    .o_parity_err(o_parity_err), .o_overflow(o_overflow), .i_clr_overflow(clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      valid_cnt++;
      last_data = o_data;
    end
    if (o_frame_err === 1'b1) ferr_cnt++;
    if (o_parity_err === 1'b1) perr_cnt++;
  end

  task automatic clear_counts();
    valid_cnt = 0;
    ferr_cnt  = 0;
    perr_cnt  = 0;
  endtask

  // Call at a negedge; returns at a negedge with the line idle.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit flip_par);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_SINK_PARITY_EN
    rx = (^b) ^ flip_par;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  function automatic void model_push(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endfunction

  task automatic check_level(input string name);
    checks++;
    if (o_level !== LVL_W'(model_q.size())) begin
      errors++;
      $display("FAIL %s level: got %0d expected %0d", name, o_level, model_q.size());
    end
  endtask

  task automatic drain(input string name);
    logic [7:0] exp;
    while (model_q.size() > 0) begin
      exp = model_q.pop_front();
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp) begin
        errors++;
        $display("FAIL %s drain: valid %b data %h expected valid 1 data %h", name, o_valid, o_data, exp);
      end
      ready = 1'b1;
      @(negedge clk);
      ready = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_level !== '0) begin
      errors++;
      $display("FAIL %s empty: valid %b level %0d expected 0 0", name, o_valid, o_level);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_level !== '0 || o_frame_err !== 1'b0 ||
        o_parity_err !== 1'b0 || o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset: valid %b level %0d ferr %b perr %b ovf %b expected all 0",
               o_valid, o_level, o_frame_err, o_parity_err, o_overflow);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single();
    ready = 1'b1;
    clear_counts();
    @(negedge clk);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    checks++;
    if (valid_cnt != 1 || last_data !== 8'h55) begin
      errors++;
      $display("FAIL single: valid cycles %0d data %h expected 1 55", valid_cnt, last_data);
    end
    checks++;
    if (ferr_cnt != 0 || perr_cnt != 0 || o_level !== '0) begin
      errors++;
      $display("FAIL single flags: ferr %0d perr %0d level %0d expected 0 0 0", ferr_cnt, perr_cnt, o_level);
    end
    ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    model_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      send_frame(8'(i), 1'b1, 1'b0);
      model_push(8'(i));
    end
    repeat (12) @(negedge clk);
    check_level("b2b");
    checks++;
    if (o_overflow !== model_ovf) begin
      errors++;
      $display("FAIL b2b overflow: got %b expected %b", o_overflow, model_ovf);
    end
    drain("b2b");
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL clr_overflow: got %b expected 0", o_overflow);
    end
  endtask

  task automatic test_frame_err();
    clear_counts();
    @(negedge clk);
    send_frame(8'hA3, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    checks++;
    if (ferr_cnt != 1 || perr_cnt != 0 || valid_cnt != 0 || o_level !== '0) begin
      errors++;
      $display("FAIL frame_err: ferr %0d perr %0d valid %0d level %0d expected 1 0 0 0",
               ferr_cnt, perr_cnt, valid_cnt, o_level);
    end
    send_frame(8'h3C, 1'b1, 1'b0);
    model_push(8'h3C);
    repeat (12) @(negedge clk);
    check_level("after_break");
    drain("after_break");
  endtask

  task automatic test_glitch();
    logic [7:0] b;
    clear_counts();
    @(negedge clk);
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    checks++;
    if (valid_cnt != 0 || ferr_cnt != 0 || perr_cnt != 0 || o_level !== '0) begin
      errors++;
      $display("FAIL glitch: valid %0d ferr %0d perr %0d level %0d expected 0 0 0 0",
               valid_cnt, ferr_cnt, perr_cnt, o_level);
    end
    b = 8'($urandom);
    send_frame(b, 1'b1, 1'b0);
    model_push(b);
    repeat (12) @(negedge clk);
    check_level("post_glitch");
    drain("post_glitch");
  endtask

  task automatic test_full_pop();
    logic [7:0] nb;
    model_ovf = 1'b0;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      nb = 8'($urandom);
      send_frame(nb, 1'b1, 1'b0);
      model_push(nb);
    end
    repeat (4) @(negedge clk);
    nb = 8'($urandom);
    fork
      send_frame(nb, 1'b1, 1'b0);
      begin
        repeat (STOP_OFF) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    void'(model_q.pop_front());
    model_push(nb);
    repeat (12) @(negedge clk);
    check_level("full_pop");
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pop overflow: got %b expected 0", o_overflow);
    end
    drain("full_pop");
  endtask

  task automatic test_random();
    logic [7:0] b;
    int         n;
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, DEPTH);
      @(negedge clk);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        b = 8'($urandom);
        send_frame(b, 1'b1, 1'b0);
        model_push(b);
      end
      repeat (12) @(negedge clk);
      check_level("random");
      drain("random");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    model_q.delete();
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0 || o_level !== '0 || o_overflow !== 1'b0 || o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: valid %b level %0d ovf %b ferr %b expected 0 0 0 0",
               o_valid, o_level, o_overflow, o_frame_err);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    model_push(8'h5A);
    repeat (12) @(negedge clk);
    check_level("reset_mid");
    drain("reset_mid");
  endtask

`ifdef UART_RX_SINK_PARITY_EN
  task automatic test_parity();
    clear_counts();
    @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b0);
    model_push(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (12) @(negedge clk);
    check_level("parity");
    checks++;
    if (perr_cnt != 1 || ferr_cnt != 0) begin
      errors++;
      $display("FAIL parity pulse: perr %0d ferr %0d expected 1 0", perr_cnt, ferr_cnt);
    end
    drain("parity");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_full_pop();
    test_random();
    test_reset_mid();
`ifdef UART_RX_SINK_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_sink.md
# uart_rx_sink

Bench-side UART receiver that consumes the `uart_0_tx` serial stream produced by the SoC simulation top level and turns it into bytes. It runs 8N1 framing (8E1 when parity is compiled in), validates start, parity and stop bits, and buffers received bytes in a small FIFO. The FIFO drains through a valid/ready stream to the testbench checker or console writer. It sits directly downstream of the SoC top's UART transmit pin and runs on the same clock.

## Interface
- `CLKS_PER_BIT`, 434: `i_clk` cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `FIFO_DEPTH`, 16: byte FIFO entries. Must be a power of two, ≥ 2.
- `LVL_W`, `$clog2(FIFO_DEPTH)+1`: width of the level output (derived).

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_rx` in 1: serial line; idle high. Connect to `uart_0_tx`.
- `o_data` out 8: FIFO head byte.
- `o_valid` out 1: `o_data` is valid.
- `i_ready` in 1: consumer accepts the head byte when `o_valid & i_ready`.
- `o_level` out LVL_W: bytes currently held, 0..FIFO_DEPTH.
- `o_frame_err` out 1: one-cycle pulse when a stop bit samples 0.
- `o_parity_err` out 1: one-cycle pulse on parity mismatch. Constant 0 without `UART_RX_SINK_PARITY_EN`.
- `o_overflow` out 1: sticky; a byte was dropped because the FIFO was full.
- `i_clr_overflow` in 1: synchronous clear of `o_overflow`.

## Operation
- `i_rx` passes through a 2-FF synchroniser. Both flops reset to 1. All decisions use the synchronised value `rxs`.
- FSM states:
  - IDLE: a 1→0 transition on `rxs` loads the bit counter with `CLKS_PER_BIT/2 - 1` and moves to START.
  - START: at counter 0, sample `rxs`. If 1 (glitch), return to IDLE with no error. If 0, go to DATA with bit index 0.
  - DATA: reload counter with `CLKS_PER_BIT-1` and sample at 0, eight times, LSB first, into the shift register. Then go to PARITY if enabled, else STOP.
  - PARITY: one bit time. Expected value is the XOR of the data bits (even parity). A mismatch sets a pending flag.
  - STOP: one bit time, then sample.
    - Sample 1 and no pending parity error: push the byte and go to IDLE.
    - Sample 1 and parity error: pulse `o_parity_err`, drop the byte, go to IDLE.
    - Sample 0: pulse `o_frame_err`, drop the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rxs` is 1, then go to IDLE. This prevents a break condition from being read as repeated start bits.
- Counter width is `$clog2(CLKS_PER_BIT)`. The counter decrements to 0 and reloads; it never wraps.
- FIFO: read and write pointers are `$clog2(FIFO_DEPTH)+1` bits wide with natural wrap.
  - Full: pointers are equal except the MSB.
  - Empty: pointers are equal.
- Push while full, with no pop in the same cycle: the byte is dropped and `o_overflow` is set.
- Push and pop in the same cycle while full: both occur, no overflow, and the level is unchanged.
- Push and pop in the same cycle while empty: the push is only visible next cycle, so no pop occurs.
- `o_valid = !empty`. `o_data` = memory at the read pointer; it is undefined when empty.
- Overflow set and `i_clr_overflow` in the same cycle: set wins.

## Timing
- Reset values:
  - FSM in IDLE.
  - `o_valid`, `o_frame_err`, `o_parity_err` and `o_overflow` all 0.
  - `o_level` 0; pointers 0; synchroniser 11.
- Take the falling edge on `i_rx` in cycle 0. `rxs` falls at cycle 2 and the FSM sees the edge at cycle 2.
  - Start sample: cycle 2 + CLKS_PER_BIT/2.
  - Data bit k sample: cycle 2 + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop sample: cycle 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT. Add one CLKS_PER_BIT with parity.
- The push is registered at the stop-sample edge. `o_valid` and `o_level` update on the next cycle.
- Error pulses are high for exactly the cycle after the stop sample.
- A start edge is accepted immediately after a good stop bit, so back-to-back frames need no extra idle time.
- Reset asserted mid-frame: the partial byte is discarded, the FIFO is emptied and all flags clear. After release, the line must go idle (high) and then fall before a new frame starts.

## Configuration
- `UART_RX_SINK_PARITY_EN` defined: the PARITY state exists, a frame is 11 bits, and `o_parity_err` is active.
- `UART_RX_SINK_PARITY_EN` undefined: the PARITY state and its logic are removed, a frame is 10 bits, and `o_parity_err` is tied to 0.

## Test plan
- Reset, then one 8N1 frame 0x55 at CLKS_PER_BIT=8 with `i_ready`=1 → `o_valid` pulses for 1 cycle with `o_data`=0x55. Frame and parity errors stay 0 and `o_level` returns to 0.
- 20 back-to-back frames 0x00..0x13 with `i_ready`=0 and FIFO_DEPTH=16 → `o_level`=16 and `o_overflow`=1. Draining then yields 0x00..0x0F in order, and `i_clr_overflow` clears the flag.
- Frame 0xA3 with the stop bit forced to 0, followed by the line held low for 3 bit times → one `o_frame_err` pulse, no push, and no spurious frames. A following 0x3C is received correctly.
- 2-cycle low glitch on an idle line → returns to IDLE with no push and no error flags.
- FIFO full with `i_ready`=1 in the stop-sample cycle of an incoming byte → the byte is accepted, `o_level` stays 16 and `o_overflow` stays 0.
- Parity build: 0x07 sent with correct even parity → pushed. 0x07 sent with the parity bit flipped → one `o_parity_err` pulse and no push.
